// File: rtl/bus_pkg.sv
// Shared types for the two-master peripheral bus arbiter.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WAIT,
      RESP
   } state_e;

   typedef logic owner_t;

   typedef struct packed {
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W-1:0]   wdata;
      logic [BUS_DATA_W/8-1:0] byteen;
   } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: on a tie the side that did not win last time
// gets the grant.
module rr_pick2
   import bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  owner_t     last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the bridge bus between the CPU (m0) and DMA/debug (m1) ports,
// one transaction at a time with a fixed read latency.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = BUS_ADDR_W,
   parameter int DATA_W     = BUS_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_req,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_byteen,
   output logic                m0_gnt,
   output logic                m0_done,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_byteen,
   output logic                m1_gnt,
   output logic                m1_done,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_byteen,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                busy
);

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [DATA_W/8-1:0] byteen;
   } req_t;

   state_e              state_q;
   owner_t              owner_q;
   owner_t              last_q;
   req_t                cur_q;
   req_t                cur_d;
   logic [2:0]          cnt_q;
   logic [DATA_W/8-1:0] byteen_q;
   logic                m0_done_q;
   logic                m1_done_q;
   logic [DATA_W-1:0]   m0_rdata_q;
   logic [DATA_W-1:0]   m1_rdata_q;
   logic [DATA_W-1:0]   resp_data;
   logic [1:0]          pick;
   logic                arb_en;
   logic                win;
   logic                is_wr;
   logic                fin;

   rr_pick2 u_pick (
      .req_i  ({m1_req, m0_req}),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   // Arbitration is live in IDLE and RESP so back-to-back has no gap.
   assign arb_en = reset && (state_q == IDLE || state_q == RESP);
   assign m0_gnt = arb_en && pick[0];
   assign m1_gnt = arb_en && pick[1];
   assign win    = pick[1];
   assign cur_d  = win ? {m1_addr, m1_wdata, m1_byteen}
                       : {m0_addr, m0_wdata, m0_byteen};

   assign is_wr     = |cur_q.byteen;
   assign resp_data = is_wr ? '0 : bus_rdata;
   assign fin = (state_q == ADDR && (is_wr || RD_LATENCY == 0))
             || (state_q == WAIT && cnt_q == 3'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         cur_q      <= '0;
         cnt_q      <= '0;
         byteen_q   <= '0;
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         byteen_q   <= '0;
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         if (fin) begin
            state_q <= RESP;
            if (owner_q) begin
               m1_done_q  <= 1'b1;
               m1_rdata_q <= resp_data;
            end else begin
               m0_done_q  <= 1'b1;
               m0_rdata_q <= resp_data;
            end
         end else begin
            unique case (state_q)
               IDLE, RESP: begin
                  if (m0_gnt || m1_gnt) begin
                     state_q  <= ADDR;
                     owner_q  <= win;
                     last_q   <= win;
                     cur_q    <= cur_d;
                     byteen_q <= cur_d.byteen;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               ADDR: begin
                  state_q <= WAIT;
                  cnt_q   <= 3'(RD_LATENCY - 1);
               end
               WAIT:    cnt_q   <= cnt_q - 3'd1;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus_addr   = cur_q.addr;
   assign bus_wdata  = cur_q.wdata;
   assign bus_byteen = byteen_q;
   assign busy       = (state_q != IDLE);
   assign m0_done    = m0_done_q;
   assign m1_done    = m1_done_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of expected done pulses,
// plus RD_LATENCY=0 and RD_LATENCY=3 instances sharing the same inputs.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0;
   logic [31:0] m0_addr = '0;
   logic [31:0] m0_wdata = '0;
   logic [3:0]  m0_byteen = '0;
   logic        m1_req = 1'b0;
   logic [31:0] m1_addr = '0;
   logic [31:0] m1_wdata = '0;
   logic [3:0]  m1_byteen = '0;
   logic        rd_ramp = 1'b0;
   logic [31:0] rd_val = '0;
   logic [31:0] cyc = '0;
   logic [31:0] bus_rdata;

   logic        m0_gnt, m0_done, m1_gnt, m1_done, busy;
   logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_byteen;

   logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done, a_busy;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata;
   logic [3:0]  a_bus_byteen;

   logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done, b_busy;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata;
   logic [3:0]  b_bus_byteen;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          id;
      logic [31:0] rdata;
      int unsigned at;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus_rdata = rd_ramp ? 32'hA000_0000 + cyc : rd_val;

   bus_arbiter #(.RD_LATENCY(1)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(m0_gnt), .m0_done(m0_done),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_done(m1_done),
      .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_byteen(bus_byteen), .bus_rdata(bus_rdata), .busy(busy)
   );

   bus_arbiter #(.RD_LATENCY(0)) u_l0 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(a_m0_gnt), .m0_done(a_m0_done),
      .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(a_m1_gnt), .m1_done(a_m1_done),
      .m1_rdata(a_m1_rdata),
      .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata),
      .bus_byteen(a_bus_byteen), .bus_rdata(bus_rdata), .busy(a_busy)
   );

   bus_arbiter #(.RD_LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(b_m0_gnt), .m0_done(b_m0_done),
      .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(b_m1_gnt), .m1_done(b_m1_done),
      .m1_rdata(b_m1_rdata),
      .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
      .bus_byteen(b_bus_byteen), .bus_rdata(bus_rdata), .busy(b_busy)
   );

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(bit id, logic [31:0] rd, int unsigned at);
      exp_t e;
      e.id = id;
      e.rdata = rd;
      e.at = at;
      exp_q.push_back(e);
   endtask

   // Negedge sample: invariants plus scoreboard pop on any done pulse.
   task automatic sample();
      exp_t e;
      @(negedge clk);
      check("excl", {m0_gnt && m1_gnt, m0_done && m1_done}, 0);
      check("rdata_idle",
            {!m0_done && m0_rdata != 0, !m1_done && m1_rdata != 0}, 0);
      if (m0_done || m1_done) begin
         check("sb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_owner", m1_done, e.id);
            check("done_rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
            check("done_cycle", cyc, e.at);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         sample();
         adv();
      end
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      sample();
      adv();
      reset = 1'b1;
   endtask

   initial begin
      int unsigned g;
      bit w;

      // Reset state, gnt held off even with a request pending.
      m0_req = 1'b1;
      sample();
      check("rst_busy", busy, 0);
      check("rst_gnt", {m1_gnt, m0_gnt}, 0);
      check("rst_byteen", bus_byteen, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_rdata", m0_rdata, 0);
      adv();
      reset = 1'b1;
      m0_req = 1'b0;
      adv();

      // Single read from m0.
      m0_req = 1'b1;
      m0_addr = 32'h0000_1000;
      m0_byteen = 4'h0;
      rd_val = 32'h0;
      sample();
      check("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
      push(0, 32'hDEAD_BEEF, cyc + 3);
      adv();
      m0_req = 1'b0;
      rd_val = 32'h1111_1111;
      sample();
      check("rd_addr_c1", bus_addr, 32'h1000);
      check("rd_busy", busy, 1);
      adv();
      rd_val = 32'hDEAD_BEEF;
      sample();
      check("rd_addr_c2", bus_addr, 32'h1000);
      check("rd_byteen_c2", bus_byteen, 0);
      adv();
      rd_val = 32'h0;
      idle(1);
      sample();
      check("rd_idle_busy", busy, 0);
      adv();

      // Single write from m1.
      m1_req = 1'b1;
      m1_addr = 32'h0000_7F00;
      m1_wdata = 32'h1234_5678;
      m1_byteen = 4'hF;
      sample();
      check("wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
      push(1, 32'h0, cyc + 2);
      adv();
      m1_req = 1'b0;
      sample();
      check("wr_byteen", bus_byteen, 4'hF);
      check("wr_wdata", bus_wdata, 32'h1234_5678);
      check("wr_addr", bus_addr, 32'h7F00);
      adv();
      sample();
      check("wr_byteen_off", bus_byteen, 0);
      adv();
      idle(1);

      // Continuous tie after reset: writes alternate m0, m1, m0, m1.
      reset_pulse();
      m0_req = 1'b1;
      m0_addr = 32'h100;
      m0_wdata = 32'hAAAA_0000;
      m0_byteen = 4'hF;
      m1_req = 1'b1;
      m1_addr = 32'h200;
      m1_wdata = 32'hBBBB_0000;
      m1_byteen = 4'h3;
      for (int i = 0; i < 4; i++) begin
         w = (i % 2) == 1;
         sample();
         check("tie_gnt", {m1_gnt, m0_gnt}, w ? 2'b10 : 2'b01);
         push(w, 32'h0, cyc + 2);
         adv();
         if (i == 3) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         sample();
         check("tie_byteen", bus_byteen, w ? 4'h3 : 4'hF);
         check("tie_busy", busy, 1);
         adv();
      end
      idle(1);
      sample();
      check("tie_idle", busy, 0);
      adv();

      // Back-to-back: a request raised during WAIT waits for RESP.
      rd_ramp = 1'b1;
      m0_req = 1'b1;
      m0_addr = 32'h2000;
      m0_byteen = 4'h0;
      sample();
      check("b2b_gnt1", m0_gnt, 1);
      g = cyc;
      push(0, 32'hA000_0000 + g + 2, g + 3);
      adv();
      m0_req = 1'b0;
      sample();
      check("b2b_addr1", bus_addr, 32'h2000);
      check("b2b_rd_byteen", bus_byteen, 0);
      adv();
      m0_req = 1'b1;
      m0_addr = 32'h2004;
      sample();
      check("b2b_own_pending", m0_gnt, 0);
      adv();
      sample();
      check("b2b_gnt2", m0_gnt, 1);
      push(0, 32'hA000_0000 + g + 5, g + 6);
      adv();
      m0_req = 1'b0;
      sample();
      check("b2b_addr2", bus_addr, 32'h2004);
      adv();
      idle(2);

      // Latency variants: all three instances take the same read.
      reset_pulse();
      m0_req = 1'b1;
      m0_addr = 32'h3000;
      m0_byteen = 4'h0;
      sample();
      check("lat_gnt", {b_m0_gnt, a_m0_gnt, m0_gnt}, 3'b111);
      g = cyc;
      push(0, 32'hA000_0000 + g + 2, g + 3);
      adv();
      m0_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         sample();
         check("l0_done", a_m0_done, k == 2);
         check("l0_rdata", a_m0_rdata,
               k == 2 ? 32'hA000_0000 + g + 1 : 32'h0);
         check("l3_done", b_m0_done, k == 5);
         check("l3_rdata", b_m0_rdata,
               k == 5 ? 32'hA000_0000 + g + 4 : 32'h0);
         adv();
      end

      // Reset during WAIT aborts without a done pulse.
      m1_req = 1'b1;
      m1_addr = 32'h4000;
      m1_byteen = 4'h0;
      sample();
      check("abort_gnt", {m1_gnt, m0_gnt}, 2'b10);
      adv();
      m1_req = 1'b0;
      idle(1);
      sample();
      check("abort_wait_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_byteen", bus_byteen, 0);
      check("abort_addr", bus_addr, 0);
      check("abort_done", {m1_done, m0_done}, 0);
      adv();
      reset = 1'b1;
      idle(3);
      m0_req = 1'b1;
      m0_addr = 32'h5000;
      m0_byteen = 4'hF;
      m1_req = 1'b1;
      m1_addr = 32'h6000;
      m1_byteen = 4'hF;
      sample();
      check("post_rst_tie", {m1_gnt, m0_gnt}, 2'b01);
      push(0, 32'h0, cyc + 2);
      adv();
      m0_req = 1'b0;
      idle(1);
      sample();
      check("post_rst_m1", m1_gnt, 1);
      push(1, 32'h0, cyc + 2);
      adv();
      m1_req = 1'b0;
      idle(3);

      check("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter that shares the single data bus into the peripheral bridge between the CPU data port (master 0) and a DMA/debug port (master 1). It accepts one transaction at a time and drives address, write data and byte enables onto the bridge. It waits a fixed read latency, then returns registered read data and a done pulse to the winning master. Ties are resolved round-robin so neither master starves.

Parameters:
RD_LATENCY, 1, cycles after the address cycle until bus rdata is valid (0..7); 0 means rdata is valid in the address cycle.
ADDR_W, 32, address width.
DATA_W, 32, data width; byteen width is DATA_W/8.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  CPU requests a transaction
m0_addr  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU write data
m0_byteen  in  4  CPU byte enables; 0 means read
m0_gnt  out  1  request accepted this cycle
m0_done  out  1  one-cycle pulse when the transaction completes
m0_rdata  out  DATA_W  read data, valid while m0_done is high
m1_req, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_done, m1_rdata  same as the m0 ports, for the DMA port
bus_addr  out  ADDR_W  to the bridge kernel address input
bus_wdata  out  DATA_W  to the bridge kernel write data input
bus_byteen  out  4  to the bridge kernel byteen input
bus_rdata  in  DATA_W  from the bridge kernel read data output
busy  out  1  a transaction is in flight (state is not IDLE)

Behaviour:
- Reset (asynchronous, active-low): state IDLE, last_grant=1 (so m0 wins the first tie). All gnt/done low, all rdata 0, bus_addr/bus_wdata/bus_byteen 0, busy 0. Reset mid-transaction aborts it with no done pulse; bus_byteen drops to 0 immediately.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE/RESP arbitration (combinational):
  - Only one req high: that master wins.
  - Both high: the master that is not last_grant wins.
  - Winner's gnt is high this cycle. addr/wdata/byteen and the owner id are latched at the clock edge, last_grant updates, next state is ADDR.
  - No req: next state is IDLE.
- ADDR, exactly one cycle: bus_addr/bus_wdata come from the latched values; bus_byteen = latched byteen.
  - Write (byteen!=0): next state RESP.
  - Read with RD_LATENCY=0: capture bus_rdata, next state RESP.
  - Otherwise: next state WAIT with counter=RD_LATENCY-1.
- WAIT: bus_addr held, bus_byteen=0. When counter==0, capture bus_rdata and go to RESP; otherwise decrement.
- RESP, one cycle: the owner's done=1 and its rdata=captured value (writes return 0). The other master's done=0. Arbitration runs in the same cycle, so back-to-back transactions have no idle gap.
- Outside ADDR/WAIT, bus_addr holds its last value and bus_byteen=0. bus_byteen is never nonzero for more than one cycle per transaction.
- Latency from gnt: write done at +2 cycles; read done at +2+RD_LATENCY cycles (+3 by default).
- Master protocol:
  - Hold req/addr/wdata/byteen stable until gnt.
  - Deassert req after gnt.
  - Re-asserting req is legal from the done cycle onward.
  - A req raised while its own transaction is outstanding is not granted before RESP.
- gnt and done are never high for both masters in the same cycle. rdata for a master is 0 except in its done cycle.

Decomposition:
- Package bus_pkg: state enum (IDLE, ADDR, WAIT, RESP); owner type (1 bit); ADDR_W/DATA_W default constants; bus request struct {addr, wdata, byteen}.
- Sub-module rr_pick2: combinational two-way round-robin chooser (req[1:0], last -> grant one-hot).
- The FSM, latches and latency counter stay in bus_arbiter.

Test Plan:
- Single read: m0_req=1, addr=0x0000_1000, byteen=0, bus_rdata returns 0xDEAD_BEEF one cycle after ADDR -> m0_gnt at cycle 0; bus_addr=0x1000 at cycles 1-2; m0_done=1 with m0_rdata=0xDEAD_BEEF at cycle 3.
- Single write: m1 writes 0x1234_5678 to 0x7F00 with byteen=0xF -> bus_byteen=0xF for exactly cycle 1; m1_done at cycle 2; m0 ports stay idle.
- Tie after reset: m0_req=m1_req=1 held continuously -> grants alternate m0, m1, m0, m1 with no idle cycle between RESP and the next ADDR.
- Back-to-back: m0 raises a new read in its done cycle -> m0_gnt in that same cycle; next ADDR the following cycle.
- RD_LATENCY=0 and RD_LATENCY=3 builds: read done at +2 and +5 cycles from gnt respectively; rdata is captured from the correct cycle (bus_rdata changes every cycle in the bench).
- Reset asserted during WAIT -> bus_byteen=0, busy=0 and all outputs 0 immediately; no done pulse after release; the first tie after release goes to m0.
